y_mult_seq: RTL

Y_MULT_SEQ -- requirements
Module: y_mult_seq

---
 rtl/y_mult_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/y_mult_seq.sv
// rtl/y_mult_seq.sv - sequential shift-add multiplier, one multiplier bit per RUN cycle
// Optional macro Y_MULT_SIGNED_EN selects two's-complement operands (magnitude multiply + final negate).
module y_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;
`ifdef Y_MULT_SIGNED_EN
  logic                 sign_q, sign_d;
`endif

  // Upper accumulator half plus carry, then the whole {carry, acc, multiplier} chain moves right one bit.
  always_comb begin
    sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    shifted = {sum, mplr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef Y_MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef Y_MULT_SIGNED_EN
          mcand_d = a[WIDTH-1] ? -a : a;
          mplr_d  = b[WIDTH-1] ? -b : b;
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
`else
          mcand_d = a;
          mplr_d  = b;
`endif
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = shifted[2*WIDTH-1:WIDTH];
        mplr_d = shifted[WIDTH-1:0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef Y_MULT_SIGNED_EN
          prod_d  = sign_q ? -shifted : shifted;
`else
          prod_d  = shifted;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy covers the capture edge through the final iteration edge; done follows one cycle behind DONE.
  always_comb begin
    busy_d = (state_d == RUN) || (state_q == RUN);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef Y_MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef Y_MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule
